// File: rtl/div_ctrl.sv
// EX-stage controller for a multi-cycle DIV/DIVU unit: operand hand-off, stall, HI/LO write, flush/watchdog cancel.
// Optional feature: define DIV_CTRL_ZERO_TRAP_EN to trap zero divisors in EX instead of dividing.
module div_ctrl #(
    parameter int unsigned DIV_LAT_MAX = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_req,
    input  logic        div_signed_in,
    input  logic [31:0] ex_reg1,
    input  logic [31:0] ex_reg2,
    input  logic        flush,
    output logic        signed_div,
    output logic [31:0] div_opdata1,
    output logic [31:0] div_opdata2,
    output logic        div_start,
    output logic        div_cancel,
    input  logic [63:0] div_res,
    input  logic        div_done,
    output logic        stallreq,
    output logic        whilo,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_timeout,
    output logic        div_zero_exc
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;

    localparam logic [5:0] LAT_MAX = 6'(DIV_LAT_MAX);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        drain_q, drain_d;
    logic        div_start_q, div_start_d;
    logic        signed_div_q, signed_div_d;
    logic [31:0] opdata1_q, opdata1_d;
    logic [31:0] opdata2_q, opdata2_d;

    logic        stall_c, whilo_c, cancel_c, timeout_c, zero_exc_c;
    logic [31:0] hi_c, lo_c;
    logic        zero_trap;
    logic        force_zero;

`ifdef DIV_CTRL_ZERO_TRAP_EN
    assign zero_trap  = (ex_reg2 == 32'd0);
    assign force_zero = 1'b0;
`else
    // The divider's zero-divisor result is undefined, so the write is forced to zero here.
    assign zero_trap  = 1'b0;
    assign force_zero = (opdata2_q == 32'd0);
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        drain_d      = drain_q;
        div_start_d  = div_start_q;
        signed_div_d = signed_div_q;
        opdata1_d    = opdata1_q;
        opdata2_d    = opdata2_q;
        stall_c      = 1'b0;
        whilo_c      = 1'b0;
        hi_c         = 32'd0;
        lo_c         = 32'd0;
        cancel_c     = 1'b0;
        timeout_c    = 1'b0;
        zero_exc_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (div_req && !flush) begin
                    if (zero_trap) begin
                        zero_exc_c = 1'b1;
                    end else begin
                        opdata1_d    = ex_reg1;
                        opdata2_d    = ex_reg2;
                        signed_div_d = div_signed_in;
                        div_start_d  = 1'b1;
                        cnt_d        = 6'd0;
                        state_d      = BUSY;
                        stall_c      = 1'b1;
                    end
                end
            end
            BUSY: begin
                cnt_d   = cnt_q + 6'd1;
                stall_c = !div_done;
                // Flush beats a same-cycle div_done; div_done beats the watchdog.
                if (flush) begin
                    cancel_c    = 1'b1;
                    div_start_d = 1'b0;
                    drain_d     = 1'b0;
                    state_d     = DRAIN;
                end else if (div_done) begin
                    whilo_c     = 1'b1;
                    hi_c        = force_zero ? 32'd0 : div_res[63:32];
                    lo_c        = force_zero ? 32'd0 : div_res[31:0];
                    div_start_d = 1'b0;
                    state_d     = DONE;
                end else if (cnt_q == LAT_MAX) begin
                    timeout_c   = 1'b1;
                    cancel_c    = 1'b1;
                    stall_c     = 1'b0;
                    div_start_d = 1'b0;
                    drain_d     = 1'b0;
                    state_d     = DRAIN;
                end
            end
            DONE: begin
                stall_c = div_req;
                state_d = IDLE;
            end
            DRAIN: begin
                stall_c = div_req;
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 6'd0;
            drain_q      <= 1'b0;
            div_start_q  <= 1'b0;
            signed_div_q <= 1'b0;
            opdata1_q    <= 32'd0;
            opdata2_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            drain_q      <= drain_d;
            div_start_q  <= div_start_d;
            signed_div_q <= signed_div_d;
            opdata1_q    <= opdata1_d;
            opdata2_q    <= opdata2_d;
        end
    end

    assign div_start    = div_start_q;
    assign signed_div   = signed_div_q;
    assign div_opdata1  = opdata1_q;
    assign div_opdata2  = opdata2_q;

    // Combinational outputs are held quiet while reset is asserted.
    assign stallreq     = stall_c    & ~rst;
    assign whilo        = whilo_c    & ~rst;
    assign hi_o         = rst ? 32'd0 : hi_c;
    assign lo_o         = rst ? 32'd0 : lo_c;
    assign div_cancel   = cancel_c   & ~rst;
    assign div_timeout  = timeout_c  & ~rst;
    assign div_zero_exc = zero_exc_c & ~rst;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: behavioural divider model, vector table, scoreboard on HI/LO writes.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_req, div_signed_in, flush;
    logic [31:0] ex_reg1, ex_reg2;
    logic        signed_div, div_start, div_cancel;
    logic [31:0] div_opdata1, div_opdata2;
    logic [63:0] div_res;
    logic        div_done;
    logic        stallreq, whilo, div_timeout, div_zero_exc;
    logic [31:0] hi_o, lo_o;

    int checks = 0;
    int failures = 0;

    logic [63:0] exp_q[$];

    int mdl_lat = 3;
    bit mdl_hang = 1'b0;
    logic m_busy, m_prev;
    int m_cnt;

    typedef struct {
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    div_ctrl dut (
        .clk(clk), .rst(rst), .div_req(div_req), .div_signed_in(div_signed_in),
        .ex_reg1(ex_reg1), .ex_reg2(ex_reg2), .flush(flush),
        .signed_div(signed_div), .div_opdata1(div_opdata1), .div_opdata2(div_opdata2),
        .div_start(div_start), .div_cancel(div_cancel), .div_res(div_res), .div_done(div_done),
        .stallreq(stallreq), .whilo(whilo), .hi_o(hi_o), .lo_o(lo_o),
        .div_timeout(div_timeout), .div_zero_exc(div_zero_exc)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mdl_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        logic [31:0] q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Divider model: starts on a rising div_start, answers after mdl_lat cycles with a one-cycle div_done.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy   <= 1'b0;
            m_prev   <= 1'b0;
            m_cnt    <= 0;
            div_done <= 1'b0;
            div_res  <= 64'd0;
        end else begin
            m_prev   <= div_start;
            div_done <= 1'b0;
            div_res  <= 64'd0;
            if (div_cancel) begin
                m_busy <= 1'b0;
            end else if (div_start && !m_prev && !m_busy) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
            end else if (m_busy) begin
                if (m_cnt == mdl_lat - 1 && !mdl_hang) begin
                    div_done <= 1'b1;
                    div_res  <= mdl_div(signed_div, div_opdata1, div_opdata2);
                    m_busy   <= 1'b0;
                end
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // Scoreboard: every HI/LO write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (whilo) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_whilo", {hi_o, lo_o}, 64'd0);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    chk("hilo_write", {hi_o, lo_o}, e);
                end
            end else begin
                chk("hilo_idle_zero", {hi_o, lo_o}, 64'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input bit s, input logic [31:0] a, input logic [31:0] b);
        div_req       = 1'b1;
        div_signed_in = s;
        ex_reg1       = a;
        ex_reg2       = b;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            step();
            @(negedge clk);
            if (div_done) seen = 1'b1;
        end
        chk(name, seen, 1);
    endtask

    task automatic run_vec(input vec_t v);
        bit seen;
        mdl_lat = v.lat;
        step();
        drive_req(v.sgn, v.a, v.b);
        exp_q.push_back({v.hi, v.lo});
        @(negedge clk);
        chk("start_stall", stallreq, 1);
        seen = 1'b0;
        for (int k = 1; k < 100 && !seen; k++) begin
            step();
            @(negedge clk);
            if (k == 1) begin
                chk("start_high", div_start, 1);
                chk("operands", {signed_div, div_opdata1, div_opdata2}, {v.sgn, v.a, v.b});
            end
            if (div_done) begin
                seen = 1'b1;
                chk("done_whilo_same_cycle", whilo, 1);
                chk("done_stall_low", stallreq, 0);
                chk("done_no_timeout", div_timeout, 0);
            end else begin
                chk("busy_stall", stallreq, 1);
                chk("busy_start_held", {div_start, div_opdata1}, {1'b1, v.a});
            end
        end
        chk("vec_done_seen", seen, 1);
        step();
        div_req = 1'b0;
        @(negedge clk);
        chk("done_state_start_low", div_start, 0);
    endtask

    vec_t vecs[7];
    int   to_k;

    initial begin
        vecs[0] = '{sgn: 1'b0, a: 32'd100,        b: 32'd7,         lat: 3,  hi: 32'd2,          lo: 32'd14};
        vecs[1] = '{sgn: 1'b1, a: 32'hFFFF_FFF9,  b: 32'd2,         lat: 5,  hi: 32'hFFFF_FFFF,  lo: 32'hFFFF_FFFD};
        vecs[2] = '{sgn: 1'b0, a: 32'hFFFF_FFF9,  b: 32'd2,         lat: 2,  hi: 32'd1,          lo: 32'h7FFF_FFFC};
        vecs[3] = '{sgn: 1'b0, a: 32'hFFFF_FFFF,  b: 32'd16,        lat: 1,  hi: 32'hF,          lo: 32'h0FFF_FFFF};
        vecs[4] = '{sgn: 1'b1, a: 32'd100,        b: 32'hFFFF_FFF9, lat: 8,  hi: 32'd2,          lo: 32'hFFFF_FFF2};
        vecs[5] = '{sgn: 1'b0, a: 32'd8,          b: 32'd2,         lat: 2,  hi: 32'd0,          lo: 32'd4};
        // Done lands exactly on the watchdog cycle: the result must still be written.
        vecs[6] = '{sgn: 1'b1, a: 32'hFFFF_FF9C,  b: 32'hFFFF_FFF9, lat: 39, hi: 32'hFFFF_FFFE,  lo: 32'd14};

        rst = 1'b1;
        flush = 1'b0;
        drive_req(1'b0, 32'd5, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_regs", {div_start, signed_div, div_opdata1, div_opdata2}, 64'd0);
        chk("rst_comb", {div_cancel, stallreq, whilo, div_timeout, div_zero_exc}, 64'd0);
        chk("rst_hilo", {hi_o, lo_o}, 64'd0);
        div_req = 1'b0;
        step();
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Back-to-back DIVU 9/3: second start rises on the 2nd edge after the first done edge.
        mdl_lat = 4;
        step();
        drive_req(1'b0, 32'd9, 32'd3);
        exp_q.push_back({32'd0, 32'd3});
        exp_q.push_back({32'd0, 32'd3});
        wait_done("b2b_first_done");
        step();
        @(negedge clk);
        chk("b2b_done_start", div_start, 0);
        chk("b2b_done_stall", stallreq, 1);
        step();
        @(negedge clk);
        chk("b2b_idle_start", div_start, 0);
        chk("b2b_idle_stall", stallreq, 1);
        step();
        @(negedge clk);
        chk("b2b_second_start", div_start, 1);
        wait_done("b2b_second_done");
        step();
        div_req = 1'b0;

        // Flush 10 cycles after start, then a new 8/2 waits out the 2 drain cycles.
        mdl_lat = 30;
        step();
        drive_req(1'b0, 32'd20, 32'd4);
        @(negedge clk);
        for (int k = 1; k < 10; k++) begin
            step();
            @(negedge clk);
            chk("pre_flush_cancel", div_cancel, 0);
        end
        step();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_cancel", div_cancel, 1);
        chk("flush_no_whilo", whilo, 0);
        step();
        flush = 1'b0;
        mdl_lat = 3;
        drive_req(1'b0, 32'd8, 32'd2);
        exp_q.push_back({32'd0, 32'd4});
        @(negedge clk);
        chk("drain1_start", div_start, 0);
        chk("drain1_stall", stallreq, 1);
        chk("drain1_cancel", div_cancel, 0);
        step();
        @(negedge clk);
        chk("drain2_start", div_start, 0);
        step();
        @(negedge clk);
        chk("post_drain_idle_start", div_start, 0);
        chk("post_drain_take_stall", stallreq, 1);
        step();
        @(negedge clk);
        chk("post_drain_start", div_start, 1);
        chk("post_drain_op1", div_opdata1, 32'd8);
        wait_done("post_flush_done");
        step();
        div_req = 1'b0;

        // Flush in the same cycle as div_done: cancel wins, no write.
        mdl_lat = 5;
        step();
        drive_req(1'b0, 32'd50, 32'd5);
        for (int k = 1; k < 7; k++) step();
        step();
        flush = 1'b1;
        @(negedge clk);
        chk("flushdone_done_seen", div_done, 1);
        chk("flushdone_no_whilo", whilo, 0);
        chk("flushdone_cancel", div_cancel, 1);
        step();
        flush = 1'b0;
        div_req = 1'b0;
        repeat (3) step();

        // Divider never answers: watchdog fires when cnt reaches 40.
        mdl_hang = 1'b1;
        step();
        drive_req(1'b0, 32'd50, 32'd5);
        @(negedge clk);
        to_k = -1;
        for (int k = 1; k <= 60 && to_k < 0; k++) begin
            step();
            @(negedge clk);
            if (div_timeout) begin
                to_k = k;
                chk("timeout_stall_low", stallreq, 0);
                chk("timeout_cancel", div_cancel, 1);
                chk("timeout_no_whilo", whilo, 0);
            end else begin
                chk("timeout_busy_stall", stallreq, 1);
            end
        end
        chk("timeout_cycle", to_k, 41);
        step();
        div_req = 1'b0;
        mdl_hang = 1'b0;
        @(negedge clk);
        chk("timeout_pulse_once", {div_timeout, div_cancel, div_start}, 64'd0);
        repeat (2) step();

        // Zero divisor DIVU 5/0.
`ifdef DIV_CTRL_ZERO_TRAP_EN
        step();
        drive_req(1'b0, 32'd5, 32'd0);
        @(negedge clk);
        chk("zero_exc_pulse", div_zero_exc, 1);
        chk("zero_no_stall", {stallreq, whilo}, 64'd0);
        step();
        div_req = 1'b0;
        @(negedge clk);
        chk("zero_no_start", {div_start, div_zero_exc}, 64'd0);
`else
        run_vec('{sgn: 1'b0, a: 32'd5, b: 32'd0, lat: 3, hi: 32'd0, lo: 32'd0});
        chk("zero_exc_tied", div_zero_exc, 0);
`endif

        // Asynchronous reset in the middle of a division.
        mdl_lat = 20;
        step();
        drive_req(1'b1, 32'd8, 32'd2);
        repeat (3) step();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_regs", {div_start, signed_div, div_opdata1}, 64'd0);
        chk("midrst_comb", {stallreq, div_cancel, whilo}, 64'd0);
        step();
        div_req = 1'b0;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_no_cancel", {div_cancel, div_start}, 64'd0);
        run_vec(vecs[5]);

        repeat (2) step();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 SHALL have parameter DIV_LAT_MAX, default 40: watchdog limit in cycles, legal range 36..63.
REQ-003 SHALL have port clk  in  1  system clock, rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-005 SHALL have port div_req  in  1  EX holds DIV/DIVU.
REQ-006 SHALL have port div_signed_in  in  1  1 selects DIV, 0 selects DIVU.
REQ-007 SHALL have port ex_reg1  in  32  dividend.
REQ-008 SHALL have port ex_reg2  in  32  divisor.
REQ-009 SHALL have port flush  in  1  pipeline flush.
REQ-010 SHALL have ports to the divider: signed_div out 1, div_opdata1 out 32, div_opdata2 out 32, div_start out 1, div_cancel out 1.
REQ-011 SHALL have ports from the divider: div_res in 64 ({remainder, quotient}), div_done in 1.
REQ-012 SHALL have port stallreq  out  1  EX stall request.
REQ-013 SHALL have ports whilo out 1, hi_o out 32, lo_o out 32 for the HI/LO write travelling with the instruction.
REQ-014 SHALL have ports div_timeout out 1 and div_zero_exc out 1, each a one-cycle pulse.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE and DRAIN, plus a 6-bit cycle counter cnt.
REQ-016 SHALL, in IDLE with div_req=1 and flush=0, register ex_reg1/ex_reg2/div_signed_in onto div_opdata1/div_opdata2/signed_div, set div_start=1, clear cnt and enter BUSY.
REQ-017 SHALL keep stallreq combinational: 1 in IDLE when a start is taken, 1 in BUSY while div_done=0, equal to div_req in DONE and DRAIN, otherwise 0.
REQ-018 SHALL hold div_start=1 and the operands stable throughout BUSY.
REQ-019 SHALL increment cnt each cycle in BUSY.
REQ-020 SHALL, in BUSY with div_done=1, drive whilo=1, hi_o=div_res[63:32] and lo_o=div_res[31:0] combinationally in that cycle, deassert stallreq, and enter DONE with div_start registered to 0.
REQ-021 SHALL spend exactly one cycle in DONE with div_start=0, then enter IDLE; a back-to-back div_req is stalled and taken on the following IDLE cycle.
REQ-022 SHALL, on flush=1 in BUSY, drive div_cancel=1 for that cycle, deassert div_start and enter DRAIN; no HI/LO write occurs, even if div_done=1 in the same cycle (flush wins).
REQ-023 SHALL, when cnt reaches DIV_LAT_MAX in BUSY without div_done, pulse div_timeout and div_cancel for one cycle, drop stallreq and enter DRAIN.
REQ-024 SHALL keep div_start=0 in DRAIN for exactly 2 cycles, ignore flush and div_done there, then enter IDLE.
REQ-025 SHALL hold whilo=0, hi_o=0 and lo_o=0 whenever no write is in progress.
REQ-026 SHALL ignore flush in IDLE and DONE other than suppressing a start.

Reset
REQ-027 SHALL, on rst=1 asynchronously, force IDLE, cnt=0, div_start=0, signed_div=0, div_opdata1=0 and div_opdata2=0.
REQ-028 SHALL, during reset, keep div_cancel, stallreq, whilo, hi_o, lo_o, div_timeout and div_zero_exc at 0.
REQ-029 SHALL, after reset released mid-operation, require no div_cancel; the divider is reset by the same rst.

Configuration
REQ-030 SHALL use macro DIV_CTRL_ZERO_TRAP_EN to select divide-by-zero handling.
REQ-031 SHALL, with DIV_CTRL_ZERO_TRAP_EN defined, respond to IDLE with div_req=1 and ex_reg2=0 by pulsing div_zero_exc for one cycle, issuing no div_start, no stall and no whilo, and remaining in IDLE.
REQ-032 SHALL, without DIV_CTRL_ZERO_TRAP_EN, forward a zero divisor to the divider like any other operand, then write hi_o=0 and lo_o=0 at div_done, with div_zero_exc tied to 0.

Verification
REQ-033 SHALL cover: DIVU 100/7 -> stallreq high until div_done; whilo=1 with hi_o=2, lo_o=14 in one cycle; done-to-whilo latency 0 cycles.
REQ-034 SHALL cover: DIV 0xFFFFFFF9 (-7) / 2 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFD.
REQ-035 SHALL cover: two back-to-back DIVU 9/3 -> second div_start rises exactly 2 cycles after first div_done; both write hi_o=0, lo_o=3.
REQ-036 SHALL cover: flush 10 cycles after start -> div_cancel pulse, no whilo, 2 DRAIN cycles, next 8/2 gives lo_o=4.
REQ-037 SHALL cover: divider model never returns div_done -> div_timeout at cnt=40, stallreq drops, div_cancel pulse.
REQ-038 SHALL cover: DIVU 5/0, run once with DIV_CTRL_ZERO_TRAP_EN (div_zero_exc pulse, no div_start) and once without (whilo with hi_o=0, lo_o=0).
